t_switch_up_arbiter: RTL



---
 rtl/t_switch_up_arbiter_if.sv | 23 ++
 rtl/t_switch_up_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/t_switch_up_arbiter_if.sv
// Child-to-parent bus bundle of one t-switch up-link arbiter.
// The master modport is the environment side; the slave modport is the arbiter side.
interface t_switch_up_arbiter_if #(
  parameter int unsigned p_sz = 52
) ();
  logic [p_sz-1:0] l_bus_i;
  logic [p_sz-1:0] r_bus_i;
  logic            l_ack_o;
  logic            r_ack_o;
  logic [p_sz-1:0] u_bus_o;
  logic            u_ready_i;
  logic [15:0]     conflict_cnt_o;

  modport master (
    output l_bus_i, r_bus_i, u_ready_i,
    input  l_ack_o, r_ack_o, u_bus_o, conflict_cnt_o
  );

  modport slave (
    input  l_bus_i, r_bus_i, u_ready_i,
    output l_ack_o, r_ack_o, u_bus_o, conflict_cnt_o
  );
endinterface

// File: rtl/t_switch_up_arbiter.sv
// Round-robin up-link arbiter of a BFT t-switch: two 2-entry child FIFOs feeding one
// registered up-bus slot, with a saturating contention counter.
module t_switch_up_arbiter #(
  parameter int unsigned num_leaves = 256,
  parameter int unsigned payload_sz = 43,
  parameter int unsigned p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int unsigned level      = 7
) (
  input logic                 clk,
  input logic                 reset,
  t_switch_up_arbiter_if.slave bus
);

  if (p_sz != 1 + $clog2(num_leaves) + payload_sz) begin : g_psz_chk
    $error("p_sz must equal 1 + log2(num_leaves) + payload_sz");
  end
  if (level > $clog2(num_leaves)) begin : g_level_chk
    $error("level exceeds tree depth");
  end

  typedef enum logic {PortL = 1'b0, PortR = 1'b1} port_e;

  logic [1:0][p_sz-1:0] in_bus;
  logic [p_sz-1:0]      mem_q [2][2];
  logic [1:0][1:0]      cnt_q, cnt_d;
  logic [1:0]           wptr_q, wptr_d;
  logic [1:0]           rptr_q, rptr_d;
  logic [1:0]           push, pop, not_empty;
  logic [p_sz-1:0]      u_bus_q, u_bus_d;
  port_e                last_q, last_d, grant;
  logic                 grant_vld, slot_free, conflict;
  logic [15:0]          conf_q, conf_d;

  assign in_bus[PortL] = bus.l_bus_i;
  assign in_bus[PortR] = bus.r_bus_i;

  always_comb begin
    push      = '0;
    pop       = '0;
    not_empty = '0;
    grant     = PortL;
    grant_vld = 1'b0;
    conflict  = 1'b0;
    u_bus_d   = u_bus_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;

    // No pop bypass: a full FIFO refuses even when it drains this cycle.
    for (int p = 0; p < 2; p++) begin
      push[p]      = in_bus[p][p_sz-1] && (cnt_q[p] != 2'd2) && reset;
      not_empty[p] = (cnt_q[p] != 2'd0);
    end

    slot_free = !u_bus_q[p_sz-1] || bus.u_ready_i;

    if (slot_free) begin
      if (not_empty[PortL] && not_empty[PortR]) begin
        conflict  = 1'b1;
        grant_vld = 1'b1;
        grant     = (last_q == PortR) ? PortL : PortR;
      end else if (not_empty[PortL]) begin
        grant_vld = 1'b1;
        grant     = PortL;
      end else if (not_empty[PortR]) begin
        grant_vld = 1'b1;
        grant     = PortR;
      end
      u_bus_d = grant_vld ? mem_q[grant][rptr_q[grant]] : '0;
    end

    if (grant_vld) begin
      last_d = grant;
    end
    pop[PortL] = grant_vld && (grant == PortL);
    pop[PortR] = grant_vld && (grant == PortR);

    for (int p = 0; p < 2; p++) begin
      cnt_d[p]  = cnt_q[p] + {1'b0, push[p]} - {1'b0, pop[p]};
      wptr_d[p] = wptr_q[p] ^ push[p];
      rptr_d[p] = rptr_q[p] ^ pop[p];
    end

    conf_d = (conflict && (conf_q != 16'hFFFF)) ? conf_q + 16'd1 : conf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      u_bus_q <= '0;
      last_q  <= PortR;
      conf_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      u_bus_q <= u_bus_d;
      last_q  <= last_d;
      conf_q  <= conf_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counts alone.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        mem_q[p][wptr_q[p]] <= in_bus[p];
      end
    end
  end

  assign bus.l_ack_o        = push[PortL];
  assign bus.r_ack_o        = push[PortR];
  assign bus.u_bus_o        = u_bus_q;
  assign bus.conflict_cnt_o = conf_q;

endmodule
